// File: rtl/mux_scan_controller_pkg.sv
// Shared definitions for the mux scan sequencer: FSM states, last channel, default dwell.
package mux_scan_controller_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    localparam logic [1:0]  CH_LAST       = 2'd3;
    localparam int unsigned DWELL_DEFAULT = 4;

endpackage

// File: rtl/mux_scan_controller_dwell_timer.sv
// Dwell timer: counts clock cycles while run is high and ticks on the last cycle of each dwell.
module dwell_timer #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == CNT_W'(DWELL - 1));

    // Free-run while enabled; restart on each tick or whenever the scan is not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_controller.sv
// Mux scan sequencer: steps the 4-to-1 mux select through channels 0..3, samples Y at the
// end of each dwell and publishes the assembled 4-bit word with a one-cycle valid pulse.
module mux_scan_controller
    import mux_scan_controller_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEFAULT,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       y_in,
    output logic       sel_a,
    output logic       sel_b,
    output logic [3:0] word_out,
    output logic       valid,
    output logic       busy
);

    scan_state_t state, state_nxt;
    logic [1:0]  ch, ch_nxt;
    logic [3:0]  partial, partial_nxt;
    logic [3:0]  word_nxt;
    logic        valid_nxt;
    logic        tick;

    dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state == ST_SCAN),
        .tick  (tick)
    );

    // Select lines and busy come straight from registers; channel is forced to 0 outside a scan.
    assign sel_a = ch[1];
    assign sel_b = ch[0];
    assign busy  = (state == ST_SCAN);

    // Next-state, channel stepping and capture of the sampled mux output.
    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        partial_nxt = partial;
        word_nxt    = word_out;
        valid_nxt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_SCAN;
                    ch_nxt      = '0;
                    partial_nxt = '0;
                end
            end
            ST_SCAN: begin
                if (tick) begin
                    partial_nxt[ch] = y_in;
                    if (ch == CH_LAST) begin
                        // Last bit is folded in directly so the word is complete on this edge.
                        word_nxt  = {y_in, partial[2:0]};
                        valid_nxt = 1'b1;
                        ch_nxt    = '0;
                        if (!cont) begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        ch_nxt = ch + 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ch_nxt    = '0;
            end
        endcase
    end

    // State, channel, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ch       <= '0;
            partial  <= '0;
            word_out <= '0;
            valid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ch       <= ch_nxt;
            partial  <= partial_nxt;
            word_out <= word_nxt;
            valid    <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Self-checking bench: a DWELL=4 and a DWELL=1 instance, each fed by a behavioural 4-to-1 mux
// over its own input bank, compared every cycle against a timeline model of the scan.
module tb_mux_scan_controller;

    logic       clk;
    logic       rst_n;
    logic       st [2];
    logic       ct [2];
    logic [3:0] bk [2];

    logic [1:0] y_w, sa_w, sb_w, valid_w, busy_w;
    logic [3:0] word_w0, word_w1;

    int checks;
    int errors;

    // Model state per instance: scan active, cycles elapsed in scan, capture, word, valid.
    int         dw   [2];
    bit         act  [2];
    int         tt   [2];
    logic [3:0] acc  [2];
    logic [3:0] wrd  [2];
    bit         vld  [2];

    assign y_w[0] = bk[0][{sa_w[0], sb_w[0]}];
    assign y_w[1] = bk[1][{sa_w[1], sb_w[1]}];

    mux_scan_controller #(.DWELL(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .cont(ct[0]), .y_in(y_w[0]),
        .sel_a(sa_w[0]), .sel_b(sb_w[0]), .word_out(word_w0), .valid(valid_w[0]), .busy(busy_w[0])
    );

    mux_scan_controller #(.DWELL(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .cont(ct[1]), .y_in(y_w[1]),
        .sel_a(sa_w[1]), .sel_b(sb_w[1]), .word_out(word_w1), .valid(valid_w[1]), .busy(busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        act[k] = 1'b0;
        tt[k]  = 0;
        acc[k] = '0;
        wrd[k] = '0;
        vld[k] = 1'b0;
    endtask

    // One clock edge of the scan timeline: channel = elapsed / dwell, sample on the last cycle.
    task automatic model_step(input int k);
        int chn;
        vld[k] = 1'b0;
        if (!act[k]) begin
            if (st[k]) begin
                act[k] = 1'b1;
                tt[k]  = 0;
            end
        end else begin
            chn = tt[k] / dw[k];
            if ((tt[k] % dw[k]) == dw[k] - 1) begin
                acc[k][chn] = bk[k][chn];
                if (chn == 3) begin
                    wrd[k] = acc[k];
                    vld[k] = 1'b1;
                    tt[k]  = 0;
                    if (!ct[k]) act[k] = 1'b0;
                end else begin
                    tt[k]++;
                end
            end else begin
                tt[k]++;
            end
        end
    endtask

    task automatic compare_all();
        check("busy4",  int'(busy_w[0]),  int'(act[0]));
        check("sel4",   int'({sa_w[0], sb_w[0]}), act[0] ? tt[0] / dw[0] : 0);
        check("valid4", int'(valid_w[0]), int'(vld[0]));
        check("word4",  int'(word_w0),    int'(wrd[0]));
        check("busy1",  int'(busy_w[1]),  int'(act[1]));
        check("sel1",   int'({sa_w[1], sb_w[1]}), act[1] ? tt[1] / dw[1] : 0);
        check("valid1", int'(valid_w[1]), int'(vld[1]));
        check("word1",  int'(word_w1),    int'(wrd[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            else        model_step(k);
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int nb4, nb1, nv4, nv1, nvld;
        checks = 0;
        errors = 0;
        dw[0]  = 4;
        dw[1]  = 1;
        model_reset(0);
        model_reset(1);

        // Reset with random inputs, then idle with no start.
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'($urandom);
            ct[k] = 1'($urandom);
            bk[k] = 4'($urandom);
        end
        for (int i = 0; i < 3; i++) cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0;
            ct[k] = 1'b0;
        end
        for (int i = 0; i < 20; i++) cycle();

        // Single scan on both builds: 1010 at DWELL=4, 0011 at DWELL=1.
        bk[0] = 4'b1010;
        bk[1] = 4'b0011;
        st[0] = 1'b1;
        st[1] = 1'b1;
        cycle();
        st[0] = 1'b0;
        st[1] = 1'b0;
        nb4 = int'(busy_w[0]); nb1 = int'(busy_w[1]);
        nv4 = 0; nv1 = 0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            nb4 += int'(busy_w[0]); nb1 += int'(busy_w[1]);
            nv4 += int'(valid_w[0]); nv1 += int'(valid_w[1]);
        end
        check("busy_len4", nb4, 16);
        check("busy_len1", nb1, 4);
        check("valid_cnt4", nv4, 1);
        check("valid_cnt1", nv1, 1);
        check("word_1010", int'(word_w0), 4'b1010);
        check("word_0011", int'(word_w1), 4'b0011);

        // Continuous mode on DWELL=4: 0110 then 1001, then drop cont mid-scan.
        bk[0] = 4'b0110;
        ct[0] = 1'b1;
        st[0] = 1'b1;
        cycle();
        st[0] = 1'b0;
        nvld = 0;
        for (int i = 0; i < 60 && nvld < 2; i++) begin
            cycle();
            if (valid_w[0]) begin
                nvld++;
                if (nvld == 1) check("cont_first", int'(word_w0), 4'b0110);
                if (nvld == 2) check("cont_second", int'(word_w0), 4'b1001);
                bk[0] = 4'b1001;
            end
        end
        check("cont_pulses", nvld, 2);
        for (int i = 0; i < 6; i++) cycle();
        ct[0] = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        check("cont_stop_idle", int'(busy_w[0]), 0);

        // Start while busy is ignored: second pulse at cycle 5 of the scan.
        bk[0] = 4'($urandom);
        st[0] = 1'b1;
        cycle();
        st[0] = 1'b0;
        nv4 = 0;
        for (int i = 1; i <= 24; i++) begin
            st[0] = (i == 5);
            cycle();
            nv4 += int'(valid_w[0]);
        end
        st[0] = 1'b0;
        check("busy_start_valids", nv4, 1);

        // Start held high in single mode on both builds.
        st[0] = 1'b1;
        st[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bk[0] = 4'($urandom);
            bk[1] = 4'($urandom);
            cycle();
        end
        st[0] = 1'b0;
        st[1] = 1'b0;
        for (int i = 0; i < 20; i++) cycle();

        // Reset mid-scan after a completed 1111 word.
        bk[0] = 4'b1111;
        st[0] = 1'b1;
        cycle();
        st[0] = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        check("prior_word", int'(word_w0), 4'b1111);
        bk[0] = 4'b0101;
        st[0] = 1'b1;
        cycle();
        st[0] = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check("rst_word", int'(word_w0), 0);
        check("rst_busy", int'(busy_w[0]), 0);
        check("rst_sel", int'({sa_w[0], sb_w[0]}), 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        nv4 = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            nv4 += int'(valid_w[0]);
        end
        check("rst_no_valid", nv4, 0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                st[k] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 15) == 0) ct[k] = 1'($urandom);
                if ($urandom_range(0, 3) == 0)  bk[k] = 4'($urandom);
            end
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0;
            ct[k] = 1'b0;
        end
        for (int i = 0; i < 20; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
- Sequencer paired with the 4-to-1 mux stage.
- Drives the mux select lines A and B through channels 0..3, holding each for a programmable dwell time.
- Samples the mux output Y at the end of each dwell and reassembles the four samples into a 4-bit word with a one-cycle valid pulse.
- Used to read back a 4-bit input bank through a single-bit path; supports single-shot and continuous scanning.

Parameters:
- DWELL, 4, clock cycles each channel is held (settle plus sample); legal range 1..256.
- CNT_W, 8, dwell counter width; must satisfy 2**CNT_W >= DWELL.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan when idle; level-sampled at rising edge.
- cont  input  1  continuous mode; sampled at the end of each scan.
- y_in  input  1  mux output Y.
- sel_a  output  1  drives mux A (select MSB).
- sel_b  output  1  drives mux B (select LSB).
- word_out  output  4  last completed scan; word_out[k] = Y sampled while {sel_a,sel_b}=k.
- valid  output  1  one-cycle pulse when word_out updates.
- busy  output  1  high while a scan is in progress.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: sel_a=0, sel_b=0, word_out=4'b0000, valid=0, busy=0, state=IDLE, dwell count=0, channel=0, partial capture=0.
- States:
  - IDLE: sel held at 00. start=1 at an edge -> SCAN, busy=1, channel=0, count=0.
  - SCAN: count increments each edge. At the edge where count==DWELL-1:
    - capture y_in into bit [channel] of the partial register and reset count to 0.
    - channel<3: channel+1; sel updates at the same edge.
    - channel==3: load word_out with the full capture (including this bit) and pulse valid=1 for the next cycle. If cont=1, channel=0, sel=00, stay in SCAN with busy=1; else go to IDLE, busy=0, sel=00.
- Latency: valid is high during the cycle following the 4*DWELL-th edge after the start edge. With DWELL=4 this is 16 edges.
- Continuous throughput: one valid pulse every 4*DWELL cycles with no gap.
- DWELL=1: sample every edge, channel advances every edge, valid 4 edges after start.
- start while busy: ignored; it does not restart or extend the scan.
- start held high in single mode: a new scan begins at the first edge where state is IDLE. The scan-to-IDLE edge returns to IDLE first, so the next edge restarts; this gives one idle cycle between scans.
- cont deasserted mid-scan: the current scan completes, then the block goes to IDLE. cont is only sampled at the last-channel sample edge.
- word_out holds its value between scans and while busy. Partial captures are never visible on word_out.
- Reset mid-scan: immediate asynchronous return to reset values; the partial word is discarded and no valid is issued.
- Channel counter is 2 bits and wraps 3->0 only in continuous mode.
- y_in is a combinational function of sel within the same clock. The DWELL>=1 hold guarantees sel is stable for at least one full cycle before capture.

Decomposition:
- Shared include file holds:
  - state encoding localparams (ST_IDLE=1'b0, ST_SCAN=1'b1);
  - CH_LAST=2'd3;
  - DWELL default.
- One sub-module: dwell_timer.
  - Parameterised by DWELL/CNT_W.
  - Inputs clk, rst_n, run; output tick, asserted when count==DWELL-1; counter clears on tick or when run=0.
  - The top level contains the FSM, channel counter, capture register, and output registers.

Test Plan:
- Bench instantiates mux_4_to_1 with sel_a->A, sel_b->B, Y->y_in.
1. Reset values: assert rst_n=0 with random inputs -> all outputs zero; release, no start -> outputs remain zero for 20 cycles.
2. Single scan: DWELL=4, I=4'b1010, pulse start one cycle -> sel sequence 00,01,10,11 each held 4 cycles; valid pulses once, 16 edges after start; word_out=4'b1010; busy=1 for exactly 16 cycles.
3. Continuous mode: cont=1, I=4'b0110, then I=4'b1001 changed between scans -> valid every 16 cycles, first word_out=0110, next=1001. Drop cont mid-scan -> that scan completes, then IDLE.
4. Start while busy: second start pulse at cycle 5 of a scan -> exactly one valid, at edge 16; no restart.
5. Reset mid-scan: rst_n low at cycle 9 of a scan with a prior word_out=4'b1111 -> word_out=0, busy=0, sel=00 immediately; no valid afterwards.
6. DWELL=1 build, I=4'b0011 -> sel changes every edge, valid at edge 4, word_out=4'b0011.
